tempo_sequencer: RTL and testbench

TEMPO_SEQUENCER -- requirements
Module: tempo_sequencer

---
 rtl/metro_pkg.sv | 24 ++
 rtl/tempo_sequencer_if.sv | 22 ++
 rtl/seq_divider.sv | 56 +++++
 rtl/tempo_sequencer.sv | 161 ++++++++++++++++
 tb/tb_tempo_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/metro_pkg.sv
// Shared tempo constants, FSM state type and tempo/preset helpers.
package metro_pkg;

  localparam int BPM_MIN    = 60;
  localparam int BPM_MAX    = 230;
  localparam int BPM_STEP   = 10;
  localparam int PRESET_MAX = (BPM_MAX - BPM_MIN) / BPM_STEP;
  localparam int PHASES     = 14;

  typedef enum logic {
    ST_DIV,
    ST_RUN
  } seq_state_t;

  // Tempo is held internally as a step count k, bpm = BPM_MIN + BPM_STEP*k.
  function automatic logic [4:0] preset_step(input logic [4:0] code);
    return (code > 5'(PRESET_MAX)) ? 5'(PRESET_MAX) : code;
  endfunction

  function automatic logic [7:0] step_to_bpm(input logic [4:0] k);
    return 8'(BPM_MIN) + 8'(BPM_STEP) * {3'b000, k};
  endfunction

endpackage

// File: rtl/tempo_sequencer_if.sv
// Switch/key inputs and display/speaker outputs of the tempo sequencer.
interface tempo_sequencer_if;
  logic [4:0] sw_preset;
  logic       tap_up_n;
  logic       tap_down_n;
  logic [7:0] beat_led;
  logic       click;
  logic [7:0] bpm;
  logic [3:0] bpm_hund;
  logic [3:0] bpm_tens;
  logic       busy;

  modport master (
    output sw_preset, tap_up_n, tap_down_n,
    input  beat_led, click, bpm, bpm_hund, bpm_tens, busy
  );

  modport slave (
    input  sw_preset, tap_up_n, tap_down_n,
    output beat_led, click, bpm, bpm_hund, bpm_tens, busy
  );
endinterface

// File: rtl/seq_divider.sv
// 32-bit restoring divider: the start cycle performs the first of 32 steps,
// done pulses with the quotient valid; clear aborts a running division.
module seq_divider (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        clear,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient
);

  logic [31:0] rem;
  logic [31:0] dvs;
  logic [4:0]  cnt;
  logic [31:0] rem_in, quo_in, dvs_in, quo_nx;
  logic [32:0] rem_sh, rem_nx;

  always_comb begin
    rem_in = busy ? rem : 32'd0;
    quo_in = busy ? quotient : dividend;
    dvs_in = busy ? dvs : divisor;
    rem_sh = {rem_in, quo_in[31]};
    rem_nx = rem_sh;
    quo_nx = {quo_in[30:0], 1'b0};
    if (rem_sh >= {1'b0, dvs_in}) begin
      rem_nx = rem_sh - {1'b0, dvs_in};
      quo_nx = {quo_in[30:0], 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    done <= 1'b0;
    if (!reset || clear) begin
      busy <= 1'b0;
      cnt  <= 5'd0;
    end else if (busy) begin
      rem      <= rem_nx[31:0];
      quotient <= quo_nx;
      cnt      <= cnt - 5'd1;
      if (cnt == 5'd1) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else if (start) begin
      rem      <= rem_nx[31:0];
      quotient <= quo_nx;
      dvs      <= divisor;
      cnt      <= 5'd31;
      busy     <= 1'b1;
    end
  end

endmodule

// File: rtl/tempo_sequencer.sv
// Metronome: preset/up/down tempo control, phase-length division and a
// 14-phase LED sweep with clicks at both ends of the sweep.
module tempo_sequencer
  import metro_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int CLICK_CYCLES = 500_000
) (
  input  logic            clock,
  input  logic            reset,
  tempo_sequencer_if.slave io
);

  localparam logic [31:0] NUMERATOR = 32'(64'(CLK_HZ) * 64'd60);

  logic [4:0]  sw_s1, sw_s2, preset_q;
  logic        up_s1, up_s2, up_prev, dn_s1, dn_s2, dn_prev;
  logic        up_press, dn_press, preset_chg, bpm_chg;
  logic [4:0]  step, step_nx;
  seq_state_t  state, state_nx;
  logic        pend, div_start, div_clear, div_busy, div_done, done_ok;
  logic [31:0] div_q, divisor;
  logic        running, last, p_pend, click_q;
  logic [3:0]  pos, pos_nx;
  logic [2:0]  idx;
  logic [31:0] pcnt, p_cur, p_next, ccnt;
  logic [4:0]  tens_total;

  always_ff @(posedge clock) begin
    sw_s1 <= io.sw_preset;
    sw_s2 <= sw_s1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      {up_s1, up_s2, up_prev} <= 3'b111;
      {dn_s1, dn_s2, dn_prev} <= 3'b111;
    end else begin
      {up_s1, up_s2, up_prev} <= {io.tap_up_n, up_s1, up_s2};
      {dn_s1, dn_s2, dn_prev} <= {io.tap_down_n, dn_s1, dn_s2};
    end
  end

  always_comb begin
    up_press   = up_prev & ~up_s2;
    dn_press   = dn_prev & ~dn_s2;
    preset_chg = (sw_s2 != preset_q);
    step_nx    = step;
    if (preset_chg)
      step_nx = preset_step(sw_s2);
    else if (up_press && !dn_press && step != 5'(PRESET_MAX))
      step_nx = step + 5'd1;
    else if (dn_press && !up_press && step != 5'd0)
      step_nx = step - 5'd1;
    bpm_chg   = (step_nx != step);
    // A change while dividing aborts; the restart is issued next cycle.
    div_start = (bpm_chg | pend) & ~div_busy;
    div_clear = bpm_chg & div_busy;
    divisor   = 32'(step_to_bpm(step_nx)) * 32'd7;
    done_ok   = div_done & ~bpm_chg;
    state_nx  = state;
    if (bpm_chg)
      state_nx = ST_DIV;
    else if (state == ST_DIV && done_ok)
      state_nx = ST_RUN;
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_DIV;
    else        state <= state_nx;
  end

  seq_divider u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .clear    (div_clear),
    .dividend (NUMERATOR),
    .divisor  (divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_comb begin
    last   = running && (pcnt == p_cur - 32'd1);
    pos_nx = (pos == 4'(PHASES - 1)) ? 4'd0 : pos + 4'd1;
    idx    = (pos <= 4'd7) ? pos[2:0] : 3'(4'd14 - pos);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      preset_q <= sw_s2;
      step     <= preset_step(sw_s2);
      pend     <= 1'b1;
      running  <= 1'b0;
      pos      <= 4'd0;
      pcnt     <= 32'd0;
      p_cur    <= 32'd0;
      p_next   <= 32'd0;
      p_pend   <= 1'b0;
      click_q  <= 1'b0;
      ccnt     <= 32'd0;
    end else begin
      preset_q <= sw_s2;
      step     <= step_nx;
      pend     <= div_clear;
      if (done_ok && !running) begin
        running <= 1'b1;
        pos     <= 4'd0;
        pcnt    <= 32'd0;
        p_cur   <= div_q;
        click_q <= 1'b1;
        ccnt    <= 32'd1;
      end else begin
        if (done_ok) begin
          p_next <= div_q;
          p_pend <= 1'b1;
        end
        if (last) begin
          pos  <= pos_nx;
          pcnt <= 32'd0;
          if (done_ok) begin
            p_cur  <= div_q;
            p_pend <= 1'b0;
          end else if (p_pend) begin
            p_cur  <= p_next;
            p_pend <= 1'b0;
          end
          click_q <= (pos_nx == 4'd0) || (pos_nx == 4'd7);
          ccnt    <= 32'd1;
        end else begin
          if (running) pcnt <= pcnt + 32'd1;
          if (click_q) begin
            if (ccnt == 32'(CLICK_CYCLES)) click_q <= 1'b0;
            else                           ccnt    <= ccnt + 32'd1;
          end
        end
      end
    end
  end

  always_comb begin
    tens_total  = 5'(BPM_MIN / BPM_STEP) + step;
    io.bpm_hund = 4'd0;
    io.bpm_tens = 4'(tens_total);
    if (tens_total >= 5'd20) begin
      io.bpm_hund = 4'd2;
      io.bpm_tens = 4'(tens_total - 5'd20);
    end else if (tens_total >= 5'd10) begin
      io.bpm_hund = 4'd1;
      io.bpm_tens = 4'(tens_total - 5'd10);
    end
  end

  assign io.bpm      = step_to_bpm(step);
  assign io.beat_led = running ? (8'd1 << idx) : 8'd0;
  assign io.click    = click_q;
  assign io.busy     = (state == ST_DIV);

endmodule

// File: tb/tb_tempo_sequencer.sv
// Directed bench for tempo_sequencer at CLK_HZ=8400, CLICK_CYCLES=50.
module tb_tempo_sequencer;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  tempo_sequencer_if intf ();

  tempo_sequencer #(.CLK_HZ(8400), .CLICK_CYCLES(50)) dut (
    .clock (clock),
    .reset (reset),
    .io    (intf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_reset(input logic [4:0] code);
    intf.sw_preset  = code;
    intf.tap_up_n   = 1'b1;
    intf.tap_down_n = 1'b1;
    reset = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic release_and_start(input string tag);
    int n;
    reset = 1'b1;
    @(negedge clock);
    n = 0;
    while (intf.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clock);
    end
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL %s busy_len: got %0d want 32", tag, n);
    end
    checks++;
    if (intf.beat_led !== 8'h01 || intf.click !== 1'b1) begin
      errors++;
      $display("FAIL %s sweep_start: led=%h click=%b want led=01 click=1", tag, intf.beat_led, intf.click);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (4) @(negedge clock);
    while (intf.busy === 1'b1 && n < 500) begin
      n++;
      @(negedge clock);
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s wait_idle: busy still %b after %0d cycles", tag, intf.busy, n);
    end
  endtask

  task automatic measure_phase(input int start_n, output int len, output logic [7:0] led,
                               output int clicks, output logic first_click);
    int n;
    led         = intf.beat_led;
    first_click = intf.click;
    clicks      = 0;
    n           = start_n;
    while (intf.beat_led === led && n < 5000) begin
      if (intf.click === 1'b1) clicks++;
      n++;
      @(negedge clock);
    end
    len = n;
  endtask

  task automatic test_reset();
    do_reset(5'd6);
    checks++;
    if (intf.beat_led !== 8'h00 || intf.click !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: led=%h click=%b want 00/0", intf.beat_led, intf.click);
    end
    checks++;
    if (intf.bpm !== 8'd120 || intf.bpm_hund !== 4'd1 || intf.bpm_tens !== 4'd2) begin
      errors++;
      $display("FAIL reset_bpm: bpm=%0d h=%0d t=%0d want 120/1/2", intf.bpm, intf.bpm_hund, intf.bpm_tens);
    end
    checks++;
    if (intf.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: got %b want 1", intf.busy);
    end
    release_and_start("reset");
  endtask

  task automatic test_sweep_click();
    int seq[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1};
    int len, clicks, total;
    logic [7:0] led;
    logic fc;
    bit   edge_ph;
    total = 0;
    for (int p = 0; p < 14; p++) begin
      measure_phase(0, len, led, clicks, fc);
      edge_ph = (seq[p] == 0) || (seq[p] == 7);
      total += len;
      checks++;
      if (led !== 8'(1 << seq[p]) || len !== 600) begin
        errors++;
        $display("FAIL sweep_phase%0d: led=%h len=%0d want led=%h len=600", p, led, len, 8'(1 << seq[p]));
      end
      checks++;
      if (clicks !== (edge_ph ? 50 : 0) || (edge_ph && fc !== 1'b1)) begin
        errors++;
        $display("FAIL click_phase%0d: clicks=%0d first=%b want %0d", p, clicks, fc, edge_ph ? 50 : 0);
      end
    end
    checks++;
    if (total !== 8400 || intf.beat_led !== 8'h01 || intf.click !== 1'b1) begin
      errors++;
      $display("FAIL sweep_period: total=%0d led=%h click=%b want 8400/01/1", total, intf.beat_led, intf.click);
    end
  endtask

  task automatic press_keys(input bit up, input bit dn);
    intf.tap_up_n   = ~up;
    intf.tap_down_n = ~dn;
    repeat (3) @(negedge clock);
    intf.tap_up_n   = 1'b1;
    intf.tap_down_n = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  // Presses one or both keys and reports whether busy rose in a 40-cycle window.
  task automatic press_watch(input bit up, input bit dn, output bit busy_seen);
    busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      intf.tap_up_n   = (i < 3) ? ~up : 1'b1;
      intf.tap_down_n = (i < 3) ? ~dn : 1'b1;
      @(negedge clock);
      if (intf.busy === 1'b1) busy_seen = 1'b1;
    end
  endtask

  task automatic test_preset_up();
    int len, clicks;
    logic [7:0] led;
    logic fc;
    bit   seen;
    do_reset(5'd0);
    release_and_start("preset0");
    checks++;
    if (intf.bpm !== 8'd60) begin
      errors++;
      $display("FAIL preset0_bpm: got %0d want 60", intf.bpm);
    end
    repeat (3) press_keys(1'b1, 1'b0);
    repeat (4) @(negedge clock);
    checks++;
    if (intf.bpm !== 8'd90 || intf.bpm_hund !== 4'd0 || intf.bpm_tens !== 4'd9) begin
      errors++;
      $display("FAIL up3_bpm: bpm=%0d h=%0d t=%0d want 90/0/9", intf.bpm, intf.bpm_hund, intf.bpm_tens);
    end
    wait_idle("up3");
    measure_phase(0, len, led, clicks, fc);
    measure_phase(0, len, led, clicks, fc);
    checks++;
    if (len !== 800) begin
      errors++;
      $display("FAIL up3_period: got %0d want 800", len);
    end
    intf.sw_preset = 5'd17;
    wait_idle("preset17");
    checks++;
    if (intf.bpm !== 8'd230 || intf.bpm_hund !== 4'd2 || intf.bpm_tens !== 4'd3) begin
      errors++;
      $display("FAIL preset17_bpm: bpm=%0d h=%0d t=%0d want 230/2/3", intf.bpm, intf.bpm_hund, intf.bpm_tens);
    end
    press_watch(1'b1, 1'b0, seen);
    checks++;
    if (intf.bpm !== 8'd230 || seen !== 1'b0) begin
      errors++;
      $display("FAIL up_at_max: bpm=%0d busy_seen=%b want 230/0", intf.bpm, seen);
    end
    measure_phase(0, len, led, clicks, fc);
    measure_phase(0, len, led, clicks, fc);
    checks++;
    if (len !== 313) begin
      errors++;
      $display("FAIL max_period: got %0d want 313", len);
    end
  endtask

  task automatic test_down_hold();
    bit seen;
    intf.sw_preset = 5'd0;
    wait_idle("preset0_live");
    press_watch(1'b0, 1'b1, seen);
    checks++;
    if (intf.bpm !== 8'd60 || seen !== 1'b0) begin
      errors++;
      $display("FAIL down_at_min: bpm=%0d busy_seen=%b want 60/0", intf.bpm, seen);
    end
  endtask

  task automatic test_both_keys();
    bit seen;
    intf.sw_preset = 5'd5;
    wait_idle("preset5");
    press_watch(1'b1, 1'b1, seen);
    checks++;
    if (intf.bpm !== 8'd110 || intf.bpm_hund !== 4'd1 || intf.bpm_tens !== 4'd1 || seen !== 1'b0) begin
      errors++;
      $display("FAIL both_keys: bpm=%0d h=%0d t=%0d busy_seen=%b want 110/1/1/0",
               intf.bpm, intf.bpm_hund, intf.bpm_tens, seen);
    end
  endtask

  task automatic test_preset_vs_up();
    intf.sw_preset = 5'd8;
    intf.tap_up_n  = 1'b0;
    repeat (3) @(negedge clock);
    intf.tap_up_n  = 1'b1;
    repeat (7) @(negedge clock);
    checks++;
    if (intf.bpm !== 8'd140 || intf.bpm_hund !== 4'd1 || intf.bpm_tens !== 4'd4) begin
      errors++;
      $display("FAIL preset_beats_up: bpm=%0d h=%0d t=%0d want 140/1/4", intf.bpm, intf.bpm_hund, intf.bpm_tens);
    end
    wait_idle("preset8");
  endtask

  task automatic test_midphase();
    int len, clicks;
    logic [7:0] led;
    logic fc;
    do_reset(5'd6);
    release_and_start("midphase");
    repeat (100) @(negedge clock);
    press_keys(1'b1, 1'b0);
    measure_phase(106, len, led, clicks, fc);
    checks++;
    if (led !== 8'h01 || len !== 600 || intf.bpm !== 8'd130) begin
      errors++;
      $display("FAIL midphase_old: led=%h len=%0d bpm=%0d want 01/600/130", led, len, intf.bpm);
    end
    measure_phase(0, len, led, clicks, fc);
    checks++;
    if (led !== 8'h02 || len !== 553) begin
      errors++;
      $display("FAIL midphase_new: led=%h len=%0d want 02/553", led, len);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset(5'd6);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    checks++;
    if (intf.busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_div_reset_busy: got %b want 1", intf.busy);
    end
    reset = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (intf.beat_led !== 8'h00 || intf.click !== 1'b0 || intf.bpm !== 8'd120 || intf.busy !== 1'b1) begin
      errors++;
      $display("FAIL div_reset_outputs: led=%h click=%b bpm=%0d busy=%b want 00/0/120/1",
               intf.beat_led, intf.click, intf.bpm, intf.busy);
    end
    release_and_start("div_reset");
    n = 0;
    while (intf.beat_led !== 8'h20 && n < 5000) begin
      n++;
      @(negedge clock);
    end
    checks++;
    if (intf.beat_led !== 8'h20) begin
      errors++;
      $display("FAIL reach_idx5: led=%h want 20", intf.beat_led);
    end
    repeat (10) @(negedge clock);
    intf.sw_preset = 5'd3;
    reset = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (intf.beat_led !== 8'h00 || intf.click !== 1'b0 || intf.bpm !== 8'd90 ||
        intf.bpm_hund !== 4'd0 || intf.bpm_tens !== 4'd9) begin
      errors++;
      $display("FAIL idx5_reset_outputs: led=%h click=%b bpm=%0d h=%0d t=%0d want 00/0/90/0/9",
               intf.beat_led, intf.click, intf.bpm, intf.bpm_hund, intf.bpm_tens);
    end
    release_and_start("idx5_reset");
  endtask

  initial begin
    reset           = 1'b0;
    intf.sw_preset  = 5'd6;
    intf.tap_up_n   = 1'b1;
    intf.tap_down_n = 1'b1;
    test_reset();
    test_sweep_click();
    test_preset_up();
    test_down_hold();
    test_both_keys();
    test_preset_vs_up();
    test_midphase();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
